// File: rtl/fifo_mon_pkg.sv
// Shared types and elaboration-time helpers for the FIFO status monitor.
// Widths are derived from DEPTH so that instantiations only need to set DEPTH.
package fifo_mon_pkg;

    typedef enum logic {
        ERR_AUTO   = 1'b0,
        ERR_STICKY = 1'b1
    } err_mode_e;

    function automatic int calc_ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int calc_lvl_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Subtraction that clamps at zero instead of wrapping.
    function automatic int sat_sub(input int a, input int b);
        return (a > b) ? (a - b) : 0;
    endfunction

endpackage

// File: rtl/sat_event_counter.sv
// Event counter that saturates at all-ones and never wraps.
// A clear coinciding with an event leaves the count at 1, because the event wins.
module sat_event_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk_in,
    input  logic             areset_b,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = inc ? WIDTH'(1) : '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk_in or negedge areset_b) begin
        if (!areset_b) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/fifo_status_monitor.sv
// Status monitor for a wrap-bit-pointer FIFO: full/empty, level, peak,
// almost flags with hysteresis, overflow/underflow flags and event counters.
module fifo_status_monitor
    import fifo_mon_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int PTR_W      = calc_ptr_w(DEPTH),
    parameter int LVL_W      = calc_lvl_w(DEPTH),
    parameter int HYST       = 1,
    parameter int STICKY_ERR = 1,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                 clk_in,
    input  logic                 areset_b,
    input  logic                 trans_write,
    input  logic                 trans_read,
    input  logic                 fifo_wenable,
    input  logic                 fifo_renable,
    input  logic [PTR_W-1:0]     write_ptr,
    input  logic [PTR_W-1:0]     read_ptr,
    input  logic [LVL_W-1:0]     afull_thresh,
    input  logic [LVL_W-1:0]     aempty_thresh,
    input  logic                 err_clear,
    output logic                 full_ind,
    output logic                 empty_ind,
    output logic [LVL_W-1:0]     level,
    output logic                 almost_full_ind,
    output logic                 almost_empty_ind,
    output logic                 overflow_ind,
    output logic                 underflow_ind,
    output logic                 ptr_err_ind,
    output logic [LVL_W-1:0]     peak_level,
    output logic [ERR_CNT_W-1:0] ovf_count,
    output logic [ERR_CNT_W-1:0] udf_count
);

    localparam err_mode_e ERR_MODE = (STICKY_ERR != 0) ? ERR_STICKY : ERR_AUTO;
    localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);
    localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);

    logic [PTR_W-1:0] diff;
    logic             diff_over;
    logic             ovf_evt;
    logic             udf_evt;
    logic             ovf_clr;
    logic             udf_clr;
    logic [LVL_W-1:0] afull_lo;
    logic [LVL_W:0]   aempty_hi;

    logic             afull_q,   afull_d;
    logic             aempty_q,  aempty_d;
    logic             ovf_q,     ovf_d;
    logic             udf_q,     udf_d;
    logic             ptr_err_q, ptr_err_d;
    logic [LVL_W-1:0] peak_q,    peak_d;

    // Modular subtraction handles the wrap bit without special cases.
    assign diff      = write_ptr - read_ptr;
    assign diff_over = (diff > DEPTH_P);
    assign full_ind  = (diff == DEPTH_P);
    assign empty_ind = (diff == '0);
    assign level     = diff_over ? DEPTH_L : LVL_W'(diff);

    assign ovf_evt = trans_write & full_ind  & ~fifo_renable;
    assign udf_evt = trans_read  & empty_ind & ~fifo_wenable;

    generate
        if (ERR_MODE == ERR_STICKY) begin : g_sticky
            assign ovf_clr = err_clear;
            assign udf_clr = err_clear;
        end else begin : g_auto
            assign ovf_clr = err_clear | fifo_renable;
            assign udf_clr = err_clear | fifo_wenable;
        end
    endgenerate

    // Release points of the hysteresis bands; the upper one is one bit wider to avoid wrap.
    assign afull_lo  = LVL_W'(sat_sub(int'(afull_thresh), HYST));
    assign aempty_hi = {1'b0, aempty_thresh} + (LVL_W + 1)'(HYST);

    always_comb begin
        afull_d = afull_q;
        if ((afull_thresh == '0) || (afull_thresh > DEPTH_L)) begin
            afull_d = 1'b0;
        end else if (level >= afull_thresh) begin
            afull_d = 1'b1;
        end else if (level < afull_lo) begin
            afull_d = 1'b0;
        end
    end

    always_comb begin
        aempty_d = aempty_q;
        if (aempty_thresh >= DEPTH_L) begin
            aempty_d = 1'b0;
        end else if (level <= aempty_thresh) begin
            aempty_d = 1'b1;
        end else if ({1'b0, level} > aempty_hi) begin
            aempty_d = 1'b0;
        end
    end

    // Events take priority over any clear arriving in the same cycle.
    always_comb begin
        ovf_d     = ovf_evt   ? 1'b1 : (ovf_clr   ? 1'b0 : ovf_q);
        udf_d     = udf_evt   ? 1'b1 : (udf_clr   ? 1'b0 : udf_q);
        ptr_err_d = diff_over ? 1'b1 : (err_clear ? 1'b0 : ptr_err_q);
        peak_d    = peak_q;
        if (err_clear) begin
            peak_d = level;
        end else if (level > peak_q) begin
            peak_d = level;
        end
    end

    always_ff @(posedge clk_in or negedge areset_b) begin
        if (!areset_b) begin
            afull_q   <= 1'b0;
            aempty_q  <= 1'b0;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
            ptr_err_q <= 1'b0;
            peak_q    <= '0;
        end else begin
            afull_q   <= afull_d;
            aempty_q  <= aempty_d;
            ovf_q     <= ovf_d;
            udf_q     <= udf_d;
            ptr_err_q <= ptr_err_d;
            peak_q    <= peak_d;
        end
    end

    sat_event_counter #(
        .WIDTH (ERR_CNT_W)
    ) u_ovf_cnt (
        .clk_in   (clk_in),
        .areset_b (areset_b),
        .inc      (ovf_evt),
        .clr      (err_clear),
        .count    (ovf_count)
    );

    sat_event_counter #(
        .WIDTH (ERR_CNT_W)
    ) u_udf_cnt (
        .clk_in   (clk_in),
        .areset_b (areset_b),
        .inc      (udf_evt),
        .clr      (err_clear),
        .count    (udf_count)
    );

    assign almost_full_ind  = afull_q;
    assign almost_empty_ind = aempty_q;
    assign overflow_ind     = ovf_q;
    assign underflow_ind    = udf_q;
    assign ptr_err_ind      = ptr_err_q;
    assign peak_level       = peak_q;

endmodule

// File: tb/tb_fifo_status_monitor.sv
// Directed bench: a sticky instance (8-bit counters) and an auto-clear
// instance (2-bit counters) share one set of stimulus.
module tb_fifo_status_monitor;
    import fifo_mon_pkg::*;

    localparam int DEPTH = 8;
    localparam int PW    = 4;
    localparam int LW    = 4;

    logic          clk_in = 1'b0;
    logic          areset_b = 1'b0;
    logic          trans_write = 1'b0, trans_read = 1'b0;
    logic          fifo_wenable = 1'b0, fifo_renable = 1'b0;
    logic [PW-1:0] write_ptr = '0, read_ptr = '0;
    logic [LW-1:0] afull_thresh = '0, aempty_thresh = '0;
    logic          err_clear = 1'b0;

    logic          s_full, s_empty, s_afull, s_aempty, s_ovf, s_udf, s_perr;
    logic [LW-1:0] s_level, s_peak;
    logic [7:0]    s_ovfc, s_udfc;
    logic          a_full, a_empty, a_afull, a_aempty, a_ovf, a_udf, a_perr;
    logic [LW-1:0] a_level, a_peak;
    logic [1:0]    a_ovfc, a_udfc;

    int checks = 0;
    int failures = 0;

    always #5 clk_in = ~clk_in;

    fifo_status_monitor #(.DEPTH(DEPTH), .HYST(1), .STICKY_ERR(ERR_STICKY), .ERR_CNT_W(8)) dut_s (
        .clk_in(clk_in), .areset_b(areset_b), .trans_write(trans_write), .trans_read(trans_read),
        .fifo_wenable(fifo_wenable), .fifo_renable(fifo_renable), .write_ptr(write_ptr),
        .read_ptr(read_ptr), .afull_thresh(afull_thresh), .aempty_thresh(aempty_thresh),
        .err_clear(err_clear), .full_ind(s_full), .empty_ind(s_empty), .level(s_level),
        .almost_full_ind(s_afull), .almost_empty_ind(s_aempty), .overflow_ind(s_ovf),
        .underflow_ind(s_udf), .ptr_err_ind(s_perr), .peak_level(s_peak),
        .ovf_count(s_ovfc), .udf_count(s_udfc));

    fifo_status_monitor #(.DEPTH(DEPTH), .HYST(1), .STICKY_ERR(ERR_AUTO), .ERR_CNT_W(2)) dut_a (
        .clk_in(clk_in), .areset_b(areset_b), .trans_write(trans_write), .trans_read(trans_read),
        .fifo_wenable(fifo_wenable), .fifo_renable(fifo_renable), .write_ptr(write_ptr),
        .read_ptr(read_ptr), .afull_thresh(afull_thresh), .aempty_thresh(aempty_thresh),
        .err_clear(err_clear), .full_ind(a_full), .empty_ind(a_empty), .level(a_level),
        .almost_full_ind(a_afull), .almost_empty_ind(a_aempty), .overflow_ind(a_ovf),
        .underflow_ind(a_udf), .ptr_err_ind(a_perr), .peak_level(a_peak),
        .ovf_count(a_ovfc), .udf_count(a_udfc));

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic test_reset();
        areset_b = 1'b0;
        tick();
        areset_b = 1'b1;
        tick();
        checks++;
        if ({s_afull, s_ovf, s_udf, s_perr, s_peak, s_ovfc, s_udfc} !== '0) begin
            failures++;
            $display("FAIL reset_sticky: afull=%b ovf=%b udf=%b perr=%b peak=%0d ovfc=%0d udfc=%0d required all 0",
                     s_afull, s_ovf, s_udf, s_perr, s_peak, s_ovfc, s_udfc);
        end
        checks++;
        if (s_empty !== 1'b1 || s_full !== 1'b0 || s_level !== 4'd0) begin
            failures++;
            $display("FAIL reset_flags: empty=%b full=%b level=%0d required 1/0/0", s_empty, s_full, s_level);
        end
        $display("reset: level=%0d empty=%b peak=%0d", s_level, s_empty, s_peak);
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 8; i++) begin
            write_ptr = PW'(i);
            #1;
            checks++;
            if (s_level !== LW'(i) || s_full !== (i == 8) || s_empty !== 1'b0) begin
                failures++;
                $display("FAIL fill_%0d: level=%0d full=%b empty=%b required %0d/%b/0",
                         i, s_level, s_full, s_empty, i, (i == 8));
            end
            $display("fill: wptr=%0d level=%0d full=%b", write_ptr, s_level, s_full);
            tick();
        end
        checks++;
        if (s_peak !== 4'd8) begin
            failures++;
            $display("FAIL fill_peak: peak=%0d required 8", s_peak);
        end
    endtask

    task automatic test_almost_full();
        logic [3:0] lv [5];
        logic       ex [5];
        lv = '{4'd5, 4'd6, 4'd5, 4'd4, 4'd4};
        ex = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        afull_thresh = 4'd6;
        for (int i = 0; i < 5; i++) begin
            write_ptr = lv[i];
            if (i == 1) begin
                #1;
                checks++;
                if (s_afull !== 1'b0) begin
                    failures++;
                    $display("FAIL afull_latency: afull=%b required 0 before the edge", s_afull);
                end
            end
            tick();
            checks++;
            if (s_afull !== ex[i] || a_afull !== ex[i]) begin
                failures++;
                $display("FAIL afull_step%0d: level=%0d afull=%b/%b required %b", i, lv[i], s_afull, a_afull, ex[i]);
            end
            $display("afull: level=%0d afull=%b", s_level, s_afull);
        end
        afull_thresh = 4'd0;
    endtask

    task automatic test_almost_empty();
        logic [3:0] lv [5];
        logic       ex [5];
        lv = '{4'd4, 4'd3, 4'd2, 4'd3, 4'd4};
        ex = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        aempty_thresh = 4'd2;
        for (int i = 0; i < 5; i++) begin
            write_ptr = lv[i];
            tick();
            checks++;
            if (s_aempty !== ex[i]) begin
                failures++;
                $display("FAIL aempty_step%0d: level=%0d aempty=%b required %b", i, lv[i], s_aempty, ex[i]);
            end
            $display("aempty: level=%0d aempty=%b", s_level, s_aempty);
        end
    endtask

    task automatic test_overflow();
        write_ptr = 4'd8;
        read_ptr  = 4'd0;
        trans_write = 1'b1;
        repeat (3) tick();
        trans_write = 1'b0;
        checks++;
        if (s_ovf !== 1'b1 || s_ovfc !== 8'd3 || a_ovf !== 1'b1 || a_ovfc !== 2'd3) begin
            failures++;
            $display("FAIL ovf_set: ovf=%b/%b count=%0d/%0d required 1/1 3/3", s_ovf, a_ovf, s_ovfc, a_ovfc);
        end
        trans_read = 1'b1;
        fifo_renable = 1'b1;
        tick();
        trans_read = 1'b0;
        fifo_renable = 1'b0;
        read_ptr = 4'd1;
        checks++;
        if (s_ovf !== 1'b1 || a_ovf !== 1'b0) begin
            failures++;
            $display("FAIL ovf_after_read: sticky=%b auto=%b required 1/0", s_ovf, a_ovf);
        end
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        checks++;
        if (s_ovf !== 1'b0 || s_ovfc !== 8'd0 || s_peak !== 4'd7) begin
            failures++;
            $display("FAIL ovf_clear: ovf=%b count=%0d peak=%0d required 0/0/7", s_ovf, s_ovfc, s_peak);
        end
        $display("overflow: ovf=%b count=%0d peak=%0d", s_ovf, s_ovfc, s_peak);
    endtask

    task automatic test_saturate_clear();
        read_ptr = 4'd0;
        trans_write = 1'b1;
        repeat (5) tick();
        checks++;
        if (a_ovfc !== 2'd3 || s_ovfc !== 8'd5) begin
            failures++;
            $display("FAIL ovf_saturate: count2=%0d count8=%0d required 3/5", a_ovfc, s_ovfc);
        end
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        trans_write = 1'b0;
        checks++;
        if (a_ovfc !== 2'd1 || a_ovf !== 1'b1 || s_ovfc !== 8'd1 || s_ovf !== 1'b1) begin
            failures++;
            $display("FAIL clear_vs_event: count=%0d/%0d ovf=%b/%b required 1/1 1/1", a_ovfc, s_ovfc, a_ovf, s_ovf);
        end
        $display("saturate: count2=%0d count8=%0d", a_ovfc, s_ovfc);
    endtask

    task automatic test_underflow();
        write_ptr = 4'd3;
        read_ptr  = 4'd3;
        trans_read = 1'b1;
        tick();
        trans_read = 1'b0;
        checks++;
        if (a_udf !== 1'b1 || a_udfc !== 2'd1 || s_udf !== 1'b1) begin
            failures++;
            $display("FAIL udf_set: auto=%b count=%0d sticky=%b required 1/1/1", a_udf, a_udfc, s_udf);
        end
        trans_write = 1'b1;
        fifo_wenable = 1'b1;
        tick();
        trans_write = 1'b0;
        fifo_wenable = 1'b0;
        checks++;
        if (a_udf !== 1'b0 || a_udfc !== 2'd1 || s_udf !== 1'b1) begin
            failures++;
            $display("FAIL udf_after_write: auto=%b count=%0d sticky=%b required 0/1/1", a_udf, a_udfc, s_udf);
        end
        $display("underflow: auto=%b sticky=%b count=%0d", a_udf, s_udf, a_udfc);
    endtask

    task automatic test_back_to_back();
        {trans_read, trans_write, fifo_wenable, fifo_renable} = 4'b1111;
        tick();
        {trans_read, trans_write, fifo_wenable, fifo_renable} = 4'b0000;
        checks++;
        if (s_udfc !== 8'd1 || s_ovfc !== 8'd1 || s_level !== 4'd0) begin
            failures++;
            $display("FAIL back_to_back: udfc=%0d ovfc=%0d level=%0d required 1/1/0", s_udfc, s_ovfc, s_level);
        end
        $display("back_to_back: udfc=%0d level=%0d", s_udfc, s_level);
    endtask

    task automatic test_wrap_ptr_err();
        write_ptr = 4'b0001;
        read_ptr  = 4'b1111;
        #1;
        checks++;
        if (s_level !== 4'd2 || s_empty !== 1'b0) begin
            failures++;
            $display("FAIL wrap_level: level=%0d empty=%b required 2/0", s_level, s_empty);
        end
        write_ptr = 4'd9;
        read_ptr  = 4'd0;
        #1;
        checks++;
        if (s_level !== 4'd8 || s_full !== 1'b0) begin
            failures++;
            $display("FAIL diff9_level: level=%0d full=%b required 8/0", s_level, s_full);
        end
        tick();
        checks++;
        if (s_perr !== 1'b1 || a_perr !== 1'b1) begin
            failures++;
            $display("FAIL ptr_err_set: perr=%b/%b required 1", s_perr, a_perr);
        end
        write_ptr = 4'd0;
        #3;
        areset_b = 1'b0;
        #1;
        checks++;
        if ({s_afull, s_aempty, s_ovf, s_udf, s_perr, s_peak, s_ovfc, s_udfc} !== '0 ||
            {a_afull, a_aempty, a_ovf, a_udf, a_perr, a_peak, a_ovfc, a_udfc} !== '0) begin
            failures++;
            $display("FAIL async_reset: perr=%b peak=%0d udf=%b ovfc=%0d udfc=%0d required all 0",
                     s_perr, s_peak, s_udf, s_ovfc, s_udfc);
        end
        $display("wrap/reset: perr=%b peak=%0d", s_perr, s_peak);
        tick();
        areset_b = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_fill();
        test_almost_full();
        test_almost_empty();
        test_overflow();
        test_saturate_clear();
        test_underflow();
        test_back_to_back();
        test_wrap_ptr_err();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_status_monitor.md
Name: fifo_status_monitor

Overview:
Parametrised successor to the FIFO monitoring-signal block. It watches a FIFO's wrap-bit read/write pointers and request/accept strobes and produces:
- full/empty flags
- occupancy level and high-water mark
- programmable almost-full/almost-empty flags with hysteresis
- overflow/underflow flags, either sticky or auto-clearing
- saturating error-event counters

It sits beside the FIFO memory core and feeds status registers and flow control.

Parameters:
DEPTH, 8, FIFO entries; power of two, >= 2.
PTR_W, $clog2(DEPTH)+1, pointer width including the wrap bit.
LVL_W, $clog2(DEPTH+1), width of level/threshold values.
HYST, 1, hysteresis in entries for the almost flags; 0 <= HYST < DEPTH.
STICKY_ERR, 1, 1 = overflow/underflow cleared only by err_clear; 0 = auto-clear on the opposite accepted access.
ERR_CNT_W, 8, width of the overflow/underflow event counters.

Ports:
clk_in  input  1  clock, rising edge
areset_b  input  1  asynchronous active-low reset
trans_write  input  1  write requested this cycle
trans_read  input  1  read requested this cycle
fifo_wenable  input  1  write accepted this cycle
fifo_renable  input  1  read accepted this cycle
write_ptr  input  PTR_W  FIFO write pointer, MSB = wrap bit
read_ptr  input  PTR_W  FIFO read pointer, MSB = wrap bit
afull_thresh  input  LVL_W  almost-full set level
aempty_thresh  input  LVL_W  almost-empty set level
err_clear  input  1  single-cycle pulse; clears sticky flags, counters and peak
full_ind  output  1  FIFO full (combinational)
empty_ind  output  1  FIFO empty (combinational)
level  output  LVL_W  current occupancy (combinational)
almost_full_ind  output  1  registered almost-full
almost_empty_ind  output  1  registered almost-empty
overflow_ind  output  1  overflow flag
underflow_ind  output  1  underflow flag
ptr_err_ind  output  1  sticky; pointer difference exceeded DEPTH
peak_level  output  LVL_W  registered high-water mark
ovf_count  output  ERR_CNT_W  saturating overflow event count
udf_count  output  ERR_CNT_W  saturating underflow event count

Behaviour:
- One clock, clk_in. Reset areset_b is asynchronous and active-low. Every flop clears to 0 on reset, including while assertion is mid-operation.
- Reset values: almost_full_ind=0, almost_empty_ind=0, overflow_ind=0, underflow_ind=0, ptr_err_ind=0, peak_level=0, ovf_count=0, udf_count=0.
- diff = (write_ptr - read_ptr) mod 2^PTR_W. level = diff truncated to LVL_W; valid range 0..DEPTH.
- full_ind = (diff == DEPTH). empty_ind = (diff == 0). Both are combinational, with zero latency from the pointers.
- ptr_err_ind: set when diff > DEPTH; cleared only by err_clear. While diff > DEPTH, level saturates to DEPTH.
- almost_full_ind (1-cycle latency):
  - next = 1 if level >= afull_thresh.
  - next = 0 if level < afull_thresh - HYST, with the subtraction saturating at 0.
  - Otherwise hold.
  - afull_thresh == 0 or > DEPTH: forced 0.
- almost_empty_ind (1-cycle latency):
  - next = 1 if level <= aempty_thresh.
  - next = 0 if level > aempty_thresh + HYST.
  - Otherwise hold.
  - aempty_thresh >= DEPTH: forced 0.
- Overflow event (ovf_evt) = trans_write & full_ind & ~fifo_renable. Underflow event (udf_evt) = trans_read & empty_ind & ~fifo_wenable.
- When STICKY_ERR=1:
  - The flag is set on its event and cleared only by err_clear.
  - If an event and err_clear occur in the same cycle, the flag stays 1 and the counter loads 1. The event wins.
- When STICKY_ERR=0, matching the previous generation:
  - overflow_ind is set on ovf_evt and cleared on fifo_renable.
  - underflow_ind is set on udf_evt and cleared on fifo_wenable.
  - err_clear also clears the flags, but an event in the same cycle wins.
- ovf_count/udf_count increment by 1 per event cycle and saturate at all-ones without wrapping. err_clear zeroes them, subject to the event-wins rule.
- peak_level: registered max(peak_level, level) each cycle. err_clear loads the current level.
- Flags use 1-cycle latency. Events sampled at edge N are visible after edge N.
- A simultaneous accepted read and write leaves level unchanged and produces no event.

Decomposition:
- Package fifo_mon_pkg holds:
  - a localparam helper function computing LVL_W/PTR_W from DEPTH
  - a saturating-subtract function for the threshold-minus-HYST computation
  - a typedef enum err_mode_e {ERR_AUTO=0, ERR_STICKY=1} for documentation and bench use
- One sub-module, sat_event_counter (params WIDTH), instantiated twice for ovf/udf. Ports: clk_in, areset_b, inc, clr, count. Clear-with-inc loads 1.

Test Plan:
1. DEPTH=8, reset, then 8 accepted writes: level steps 1..8; full_ind=1 at ptr diff 8; empty_ind=0; peak_level=8.
2. afull_thresh=6, HYST=1: fill to 6 -> almost_full_ind=1 one cycle later. Drain to 5 -> stays 1. Drain to 4 -> 0 next cycle.
3. STICKY_ERR=1, full, trans_write without renable for 3 cycles -> overflow_ind=1, ovf_count=3. A later read keeps overflow_ind=1. err_clear -> 0/0.
4. STICKY_ERR=0, empty, trans_read without wenable -> underflow_ind=1, udf_count=1. One accepted write -> underflow_ind=0 next cycle, udf_count still 1.
5. ERR_CNT_W=2, 5 overflow events -> ovf_count saturates at 3. err_clear concurrent with an event -> ovf_count=1, overflow_ind=1.
6. Pointer wrap: write_ptr=4'b0001, read_ptr=4'b1111 -> level=2. Then force diff=9 -> ptr_err_ind=1, level=8. Assert areset_b mid-run -> all registered outputs return to 0 immediately.
